// File: rtl/dsp_fetch_seq.sv
// Program sequencer for the DSP core: drives the instruction ROM address and
// forwards the fetched word to Decode. Supports stall, call/return through a
// hardware return-address stack, one zero-overhead hardware loop, and status.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stall             hold PC, stack and loop state
//   jump_flag/addr    redirect PC to jump_addr
//   call_flag         push PC+1, redirect PC to jump_addr
//   ret_flag          pop the return stack into PC
//   loop_set          arm the hardware loop (top = PC+1, end = loop_end)
//   loop_end          last address of the loop body
//   loop_count        loop iterations (0 behaves as 1)
//   read_addr         ROM address (current PC)
//   read_data         ROM data (asynchronous read)
//   instruction_out   read_data passed through combinationally
//   inst_valid        instruction_out meaningful (set after reset release)
//   loop_active       hardware loop armed
//   stack_depth       return-stack entry count
//   stack_err         sticky overflow/underflow flag
module dsp_fetch_seq #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned INST_W      = 32,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned CNT_W       = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             jump_flag,
  input  logic [ADDR_W-1:0]                jump_addr,
  input  logic                             call_flag,
  input  logic                             ret_flag,
  input  logic                             loop_set,
  input  logic [ADDR_W-1:0]                loop_end,
  input  logic [CNT_W-1:0]                 loop_count,
  output logic [ADDR_W-1:0]                read_addr,
  input  logic [INST_W-1:0]                read_data,
  output logic [INST_W-1:0]                instruction_out,
  output logic                             inst_valid,
  output logic                             loop_active,
  output logic [$clog2(STACK_DEPTH):0]     stack_depth,
  output logic                             stack_err
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned DEP_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [DEP_W-1:0]  depth_q, depth_d;
  logic              err_q, err_d;
  logic              valid_q;
  logic              la_q, la_d;
  logic [ADDR_W-1:0] top_q, top_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              push_en;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_ADDR;
      depth_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      la_q    <= 1'b0;
      top_q   <= '0;
      end_q   <= '0;
      rem_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      valid_q <= 1'b1;
      la_q    <= la_d;
      top_q   <= top_d;
      end_q   <= end_d;
      rem_q   <= rem_d;
    end
  end

  // Return-stack storage; contents need no reset
  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      stack_mem[depth_q[PTR_W-1:0]] <= pc_inc;
    end
  end

  // Next-PC priority: stall > ret > call > jump > loop-back > increment
  always_comb begin
    pc_inc  = pc_q + ADDR_W'(1);
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    la_d    = la_q;
    top_d   = top_q;
    end_d   = end_q;
    rem_d   = rem_q;
    push_en = 1'b0;

    if (!stall) begin
      // A new loop_set overwrites loop state; the PC decision below still
      // uses the loop state that was armed before this edge.
      if (loop_set) begin
        top_d = pc_inc;
        end_d = loop_end;
        rem_d = (loop_count == '0) ? CNT_W'(1) : loop_count;
        la_d  = 1'b1;
      end

      if (ret_flag) begin
        if (depth_q != '0) begin
          pc_d    = stack_mem[PTR_W'(depth_q - DEP_W'(1))];
          depth_d = depth_q - DEP_W'(1);
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (call_flag) begin
        if (depth_q < DEP_W'(STACK_DEPTH)) begin
          push_en = 1'b1;
          depth_d = depth_q + DEP_W'(1);
        end else begin
          err_d = 1'b1;
        end
        pc_d = jump_addr;
      end else if (jump_flag) begin
        pc_d = jump_addr;
      end else if (la_q && (pc_q == end_q)) begin
        if (rem_q > CNT_W'(1)) begin
          pc_d = top_q;
          if (!loop_set) rem_d = rem_q - CNT_W'(1);
        end else begin
          pc_d = pc_inc;
          if (!loop_set) la_d = 1'b0;
        end
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  assign read_addr       = pc_q;
  assign instruction_out = read_data;
  assign inst_valid      = valid_q;
  assign loop_active     = la_q;
  assign stack_depth     = depth_q;
  assign stack_err       = err_q;

endmodule

// File: tb/tb_dsp_fetch_seq.sv
// Directed bench for dsp_fetch_seq. The driver issues one cycle of stimulus
// at a time and queues the expected post-edge state; a negedge monitor pops
// and compares against the DUT.
module tb_dsp_fetch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        jump_flag = 1'b0;
  logic [15:0] jump_addr = '0;
  logic        call_flag = 1'b0;
  logic        ret_flag = 1'b0;
  logic        loop_set = 1'b0;
  logic [15:0] loop_end = '0;
  logic [7:0]  loop_count = '0;
  logic [15:0] read_addr;
  logic [31:0] read_data;
  logic [31:0] instruction_out;
  logic        inst_valid;
  logic        loop_active;
  logic [2:0]  stack_depth;
  logic        stack_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] pc;
    logic        valid;
    logic        la;
    logic [2:0]  dep;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  // ROM model: tagged address so instruction_out can be predicted
  assign read_data = {16'hA5C3, read_addr};

  dsp_fetch_seq #(
    .ADDR_W(16), .INST_W(32), .STACK_DEPTH(4), .CNT_W(8), .RESET_ADDR(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .jump_flag(jump_flag), .jump_addr(jump_addr),
    .call_flag(call_flag), .ret_flag(ret_flag),
    .loop_set(loop_set), .loop_end(loop_end), .loop_count(loop_count),
    .read_addr(read_addr), .read_data(read_data),
    .instruction_out(instruction_out), .inst_valid(inst_valid),
    .loop_active(loop_active), .stack_depth(stack_depth), .stack_err(stack_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare every cycle that has a queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("read_addr", 32'(read_addr), 32'(e.pc));
      chk("inst_valid", 32'(inst_valid), 32'(e.valid));
      chk("loop_active", 32'(loop_active), 32'(e.la));
      chk("stack_depth", 32'(stack_depth), 32'(e.dep));
      chk("stack_err", 32'(stack_err), 32'(e.err));
      chk("instruction_out", instruction_out, {16'hA5C3, e.pc});
    end
  end

  // One clock of stimulus: inputs are already driven; queue expected state
  task automatic tick(input logic [15:0] pc, input logic v, input logic la,
                      input logic [2:0] dep, input logic err);
    exp_t e;
    @(posedge clk);
    e.pc = pc; e.valid = v; e.la = la; e.dep = dep; e.err = err;
    exp_q.push_back(e);
    #1;
    rst = 1'b0; stall = 1'b0; jump_flag = 1'b0; call_flag = 1'b0;
    ret_flag = 1'b0; loop_set = 1'b0;
  endtask

  task automatic do_jump(input logic [15:0] a);
    jump_flag = 1'b1; jump_addr = a;
  endtask

  task automatic do_call(input logic [15:0] a);
    call_flag = 1'b1; jump_addr = a;
  endtask

  initial begin
    // Reset, then free-running increment
    rst = 1'b1;               tick(16'h0000, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) tick(16'(i), 1, 0, 0, 0);

    // Call at PC=10 then return at 0x42
    do_jump(16'd10);          tick(16'd10,   1, 0, 0, 0);
    do_call(16'h0040);        tick(16'h0040, 1, 0, 1, 0);
                              tick(16'h0041, 1, 0, 1, 0);
                              tick(16'h0042, 1, 0, 1, 0);
    ret_flag = 1'b1;          tick(16'd11,   1, 0, 0, 0);

    // Five nested calls (overflow on the fifth), then five returns
    do_call(16'h0100);        tick(16'h0100, 1, 0, 1, 0);
    do_call(16'h0200);        tick(16'h0200, 1, 0, 2, 0);
    do_call(16'h0300);        tick(16'h0300, 1, 0, 3, 0);
    do_call(16'h0400);        tick(16'h0400, 1, 0, 4, 0);
    do_call(16'h0500);        tick(16'h0500, 1, 0, 4, 1);
    ret_flag = 1'b1;          tick(16'h0301, 1, 0, 3, 1);
    ret_flag = 1'b1;          tick(16'h0201, 1, 0, 2, 1);
    ret_flag = 1'b1;          tick(16'h0101, 1, 0, 1, 1);
    ret_flag = 1'b1;          tick(16'h000C, 1, 0, 0, 1);
    ret_flag = 1'b1;          tick(16'h000D, 1, 0, 0, 1);
    rst = 1'b1;               tick(16'h0000, 0, 0, 0, 0);

    // Hardware loop: 3 iterations of 21..22
    do_jump(16'd20);          tick(16'd20, 1, 0, 0, 0);
    loop_set = 1'b1; loop_end = 16'd22; loop_count = 8'd3;
                              tick(16'd21, 1, 1, 0, 0);
                              tick(16'd22, 1, 1, 0, 0);
                              tick(16'd21, 1, 1, 0, 0);
                              tick(16'd22, 1, 1, 0, 0);
                              tick(16'd21, 1, 1, 0, 0);
                              tick(16'd22, 1, 1, 0, 0);
                              tick(16'd23, 1, 0, 0, 0);

    // Stall for 3 cycles at PC=7; jump during stall is ignored
    do_jump(16'd7);           tick(16'd7, 1, 0, 0, 0);
    stall = 1'b1;             tick(16'd7, 1, 0, 0, 0);
    stall = 1'b1; do_jump(16'h0099); tick(16'd7, 1, 0, 0, 0);
    stall = 1'b1;             tick(16'd7, 1, 0, 0, 0);
                              tick(16'd8, 1, 0, 0, 0);

    // loop_count 0 behaves as a single pass
    loop_set = 1'b1; loop_end = 16'd9; loop_count = 8'd0;
                              tick(16'd9,  1, 1, 0, 0);
                              tick(16'd10, 1, 0, 0, 0);

    // Jump at loop_end wins and does not consume an iteration
    loop_set = 1'b1; loop_end = 16'd11; loop_count = 8'd2;
                              tick(16'd11,   1, 1, 0, 0);
    do_jump(16'h0030);        tick(16'h0030, 1, 1, 0, 0);
    do_jump(16'd11);          tick(16'd11,   1, 1, 0, 0);
                              tick(16'd11,   1, 1, 0, 0);
                              tick(16'd12,   1, 0, 0, 0);

    // Wrap of PC+1, free and as a pushed return address
    do_jump(16'hFFFF);        tick(16'hFFFF, 1, 0, 0, 0);
                              tick(16'h0000, 1, 0, 0, 0);
    do_jump(16'hFFFF);        tick(16'hFFFF, 1, 0, 0, 0);
    do_call(16'h0050);        tick(16'h0050, 1, 0, 1, 0);
    ret_flag = 1'b1;          tick(16'h0000, 1, 0, 0, 0);

    // Simultaneous flags: call beats jump, ret beats call
    do_call(16'h0060); jump_flag = 1'b1; tick(16'h0060, 1, 0, 1, 0);
    do_call(16'h0070); ret_flag = 1'b1;  tick(16'h0001, 1, 0, 0, 0);

    // Reset in the middle of a loop with a stack entry
    do_jump(16'h0080);        tick(16'h0080, 1, 0, 0, 0);
    do_call(16'h0090);        tick(16'h0090, 1, 0, 1, 0);
    loop_set = 1'b1; loop_end = 16'h0092; loop_count = 8'd5;
                              tick(16'h0091, 1, 1, 1, 0);
                              tick(16'h0092, 1, 1, 1, 0);
    rst = 1'b1;               tick(16'h0000, 0, 0, 0, 0);
                              tick(16'h0001, 1, 0, 0, 0);
    do_jump(16'h0092);        tick(16'h0092, 1, 0, 0, 0);
                              tick(16'h0093, 1, 0, 0, 0);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
